// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with turnaround cycles; optional hold timeout via BUS_ARB_TIMEOUT_EN
module bus_arbiter #(
  parameter int N_REQ = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     timeout
);
  localparam int OW = $clog2(N_REQ);
  localparam int CW = TURNAROUND > 1 ? $clog2(TURNAROUND) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  state_t state;
  logic [OW-1:0] last, win;
  logic [CW-1:0] cnt;
  logic release_now;
  int j;
  always_comb begin
    win = last;
    j = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      j = int'(last) + i;
      j = j >= N_REQ ? j - N_REQ : j;
      win = req[j] ? OW'(j) : win;
    end
  end
  assign busy = |gnt;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold;
  logic expire;
  assign expire = req[owner] && hold == HW'(MAX_HOLD - 1);
  assign release_now = !req[owner] || expire;
  always_ff @(posedge clk)
    if (rst) begin
      hold <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= state == GRANT && expire;
      hold <= state == GRANT ? hold + 1'b1 : '0;
    end
`else
  assign release_now = !req[owner];
  assign timeout = 1'b0 & (MAX_HOLD > 0);
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      owner <= '0;
      last <= OW'(N_REQ - 1);
      cnt <= '0;
    end else begin
      case (state)
        GRANT:
          if (release_now) begin
            state <= TURN;
            gnt <= '0;
            owner <= '0;
            cnt <= CW'(TURNAROUND - 1);
          end
        default:
          if (state == TURN && cnt != '0) cnt <= cnt - 1'b1;
          else if (|req) begin
            state <= GRANT;
            gnt <= N_REQ'(1) << win;
            owner <= win;
            last <= win;
          end else state <= IDLE;
      endcase
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the 32-bit tri-state data bus among up to N_REQ requesters in the GPIO/factorial system. It generates the one-hot `control` enables for each requester's bus buffer and guarantees that at most one buffer drives the bus in any cycle. It inserts dead (turnaround) cycles between owners so two drivers never overlap on a hand-off.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `TURNAROUND`, 1: dead cycles between successive grants, at least 1.
- `MAX_HOLD`, 16: maximum consecutive grant cycles. Used only when `BUS_ARB_TIMEOUT_EN` is defined.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  request per requester; held high for the whole transfer.
- `gnt`  out  N_REQ  registered one-hot grant; drives the buffer `control` inputs directly.
- `owner`  out  $clog2(N_REQ)  index of the current grantee; 0 when no grant is active.
- `busy`  out  1  high while any `gnt` bit is high.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- States: IDLE, GRANT, TURN.
- IDLE:
  - `gnt` is 0.
  - If any `req` is high, pick the first requester with `req` high, searching upward from `(last+1) mod N_REQ` with wrap-around.
  - On the next edge: go to GRANT, set that requester's `gnt` bit and `owner`, and set `last` to the winner.
- GRANT:
  - `gnt` holds while `req[owner]` stays high.
  - When `req[owner]` is sampled low, go to TURN and clear `gnt` on the same edge.
  - `req` changes on non-owners have no effect during GRANT.
- TURN:
  - `gnt` is 0 and a counter loads `TURNAROUND-1`.
  - While the counter is nonzero, decrement it.
  - When the counter is 0 and any `req` is high, arbitrate exactly as in IDLE and go straight to GRANT.
  - When the counter is 0 and no `req` is high, go to IDLE.
- Priority: `last` resets to N_REQ-1, so requester 0 wins the first arbitration after reset.
- Fairness: a requester that just released the bus has lowest priority in the next arbitration.
- Simultaneous events: if the owner drops `req` in the same cycle others raise `req`, TURN still occurs; no back-to-back grants without a dead cycle.
- A new request arriving in the last TURN cycle is eligible in that cycle's arbitration.
- Invariant: `gnt` is always one-hot or zero; `busy` equals OR of `gnt`.

## Timing
- Reset: on an edge with `rst` high, all of the following take effect on that edge, regardless of state (mid-grant included):
  - `gnt`=0, `owner`=0, `busy`=0, `timeout`=0.
  - State=IDLE, `last`=N_REQ-1, counters=0.
- Request latency from IDLE: `req` sampled high at edge k gives `gnt` high after edge k (1 cycle).
- Release latency: `req[owner]` sampled low at edge k gives `gnt` low after edge k.
- Hand-off:
  - Bus is undriven for exactly TURNAROUND cycles between the old `gnt` falling and the new `gnt` rising.
  - Minimum grant-to-grant spacing: 1 + TURNAROUND cycles.
- All outputs are registered; no combinational path from `req` to `gnt`.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the owner has held `gnt` for MAX_HOLD cycles with `req` still high, the grant is revoked on the next edge and the state goes to TURN.
  - `timeout` pulses high for one cycle, coincident with `gnt` falling.
  - `last` is set to the revoked owner, so the owner is re-granted only after other pending requesters, or after TURN if it is alone.
- `BUS_ARB_TIMEOUT_EN` not defined:
  - No hold counter is built and `timeout` is tied to 0.
  - A grant is held indefinitely while `req[owner]` is high.

## Test plan
- Reset then single request (N_REQ=4): `req`=4'b0100 held 5 cycles, then dropped.
  - `gnt`=4'b0100 and `owner`=2 one cycle after `req`.
  - `gnt` returns to 0 one cycle after the drop.
- Round-robin: `req`=4'b1111 held continuously, each owner releasing after 2 cycles.
  - Grants follow 0,1,2,3,0.
  - Exactly 1 dead cycle between each grant (TURNAROUND=1).
- Hand-off collision: owner 1 drops `req` in the same cycle requester 3 raises `req`.
  - Zero-`gnt` cycle appears, then `gnt`=4'b1000.
  - Checker asserts one-hot-or-zero `gnt` every cycle.
- Reset mid-operation: assert `rst` for 1 cycle while `gnt`=4'b0010 with `req`=4'b1010.
  - `gnt`=0 after that edge.
  - Next grant goes to requester 1 (`last` reset, search starts at 0).
- Timeout (`BUS_ARB_TIMEOUT_EN`, MAX_HOLD=16): requester 0 holds `req`, requester 2 requests at cycle 3.
  - `timeout` pulses after 16 grant cycles.
  - `gnt` goes 0 for 1 cycle, then `gnt`=4'b0100.
- Without the macro, same stimulus:
  - Requester 0 keeps `gnt` for 40 cycles.
  - `timeout` stays 0.
